// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow logic.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    SCORED,
    GAME_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/score_sequencer_if.sv
// Signal bundle between ball logic, the score sequencer and the score digits.
interface score_sequencer_if;
  import pong_pkg::*;

  logic       frame_tick;
  logic       goal_left;
  logic       goal_right;
  logic       new_game;
  logic       left_inc;
  logic       right_inc;
  logic       score_clr;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic       serve;
  logic       serve_dir;
  logic [1:0] winner;
  logic       blink;

  modport master (
    output frame_tick, goal_left, goal_right, new_game,
    input  left_inc, right_inc, score_clr, left_score, right_score,
    input  serve, serve_dir, winner, blink
  );

  modport slave (
    input  frame_tick, goal_left, goal_right, new_game,
    output left_inc, right_inc, score_clr, left_score, right_score,
    output serve, serve_dir, winner, blink
  );

endinterface

// File: rtl/frame_timer.sv
// Counts frame ticks up to a terminal count; done pulses on the tick that reaches it.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] tc,
  output logic       done
);

  logic [7:0] count;

  // A tick during clear is deliberately not counted.
  assign done = tick & ~clr & (count == tc - 8'd1);

  always_ff @(posedge clk) begin
    if (rst || clr || done) count <= 8'd0;
    else if (tick)          count <= count + 8'd1;
  end

endmodule

// File: rtl/score_sequencer.sv
// Pong game-flow controller: scores, post-goal pause, serve timing, winner detect.
// Define SCORE_BLINK_EN to enable the winner-digit blink in GAME_OVER.
//
//   state      | meaning
//   IDLE       | power-up, waiting for new_game
//   SERVE_WAIT | counting SERVE_FRAMES before releasing the ball
//   PLAY       | ball live, first goal edge scores
//   SCORED     | post-goal pause of SCORED_FRAMES
//   GAME_OVER  | winner shown until new_game
module score_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE     = 9,
  parameter int SCORED_FRAMES = 30,
  parameter int SERVE_FRAMES  = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input logic              clk,
  input logic              rst,
  score_sequencer_if.slave bus
);

  state_t     state, next_state;
  logic       goal_left_d, goal_right_d;
  logic       left_edge, right_edge;
  logic       entry_q;
  logic       left_inc_q, right_inc_q;
  logic [3:0] left_score_q, right_score_q;
  logic       serve_dir_q;
  logic [1:0] winner_q;
  logic       serve_c;
  logic       timer_tick, timer_done;
  logic [7:0] timer_tc;

  assign left_edge  = bus.goal_left & ~goal_left_d;
  assign right_edge = bus.goal_right & ~goal_right_d;

  frame_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry_q | bus.new_game),
    .tick (timer_tick),
    .tc   (timer_tc),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    serve_c    = 1'b0;
    timer_tick = 1'b0;
    timer_tc   = 8'(SERVE_FRAMES);
    case (state)
      IDLE: ;
      SERVE_WAIT: begin
        timer_tick = bus.frame_tick;
        if (timer_done) begin
          serve_c    = 1'b1;
          next_state = PLAY;
        end
      end
      PLAY: if (left_edge || right_edge) next_state = SCORED;
      SCORED: begin
        timer_tick = bus.frame_tick;
        timer_tc   = 8'(SCORED_FRAMES);
        if (timer_done)
          next_state = (left_score_q == 4'(WIN_SCORE) || right_score_q == 4'(WIN_SCORE))
                       ? GAME_OVER : SERVE_WAIT;
      end
      GAME_OVER: begin
        timer_tc = 8'(BLINK_FRAMES);
`ifdef SCORE_BLINK_EN
        timer_tick = bus.frame_tick;
`endif
      end
      default: next_state = IDLE;
    endcase
    // Restart outranks everything, including a goal or serve in the same cycle.
    if (bus.new_game) begin
      next_state = SERVE_WAIT;
      serve_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      goal_left_d   <= 1'b0;
      goal_right_d  <= 1'b0;
      entry_q       <= 1'b0;
      left_inc_q    <= 1'b0;
      right_inc_q   <= 1'b0;
      left_score_q  <= 4'd0;
      right_score_q <= 4'd0;
      serve_dir_q   <= DIR_LEFT;
      winner_q      <= WIN_NONE;
    end else begin
      goal_left_d  <= bus.goal_left;
      goal_right_d <= bus.goal_right;
      entry_q      <= (next_state != state) || bus.new_game;
      left_inc_q   <= 1'b0;
      right_inc_q  <= 1'b0;
      if (bus.new_game) begin
        left_score_q  <= 4'd0;
        right_score_q <= 4'd0;
        serve_dir_q   <= DIR_LEFT;
        winner_q      <= WIN_NONE;
      end else if (state == PLAY) begin
        if (left_edge) begin
          left_inc_q   <= 1'b1;
          left_score_q <= left_score_q + 4'd1;
          serve_dir_q  <= DIR_RIGHT;
        end else if (right_edge) begin
          right_inc_q   <= 1'b1;
          right_score_q <= right_score_q + 4'd1;
          serve_dir_q   <= DIR_LEFT;
        end
      end else if (state == SCORED && timer_done) begin
        if (left_score_q == 4'(WIN_SCORE))       winner_q <= WIN_LEFT;
        else if (right_score_q == 4'(WIN_SCORE)) winner_q <= WIN_RIGHT;
      end
    end
  end

`ifdef SCORE_BLINK_EN
  logic blink_q;

  always_ff @(posedge clk) begin
    if (rst || bus.new_game)                              blink_q <= 1'b0;
    else if (next_state == GAME_OVER && state != GAME_OVER) blink_q <= 1'b1;
    else if (state != GAME_OVER)                          blink_q <= 1'b0;
    else if (timer_done)                                  blink_q <= ~blink_q;
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

  // Pulses are masked by restart and reset so they never overlap score_clr.
  assign bus.left_inc    = left_inc_q & ~bus.new_game & ~rst;
  assign bus.right_inc   = right_inc_q & ~bus.new_game & ~rst;
  assign bus.score_clr   = bus.new_game & ~rst;
  assign bus.serve       = serve_c & ~rst;
  assign bus.left_score  = left_score_q;
  assign bus.right_score = right_score_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: vector tables plus multi-cycle game sequences.
module tb_score_sequencer;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  score_sequencer_if sif ();

  score_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

`ifdef SCORE_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic       ft, gl, gr, ng;
    logic       li, ri, clr, srv;
    logic [3:0] ls, rs;
    logic       dir;
    logic [1:0] win;
    state_t     st;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   li_cnt, ri_cnt, srv_cnt, srv_at;

  function automatic void add(string tag, logic ft, gl, gr, ng, li, ri, clr, srv,
                              logic [3:0] ls, rs, logic dir, logic [1:0] win, state_t st);
    vec_t x;
    x.tag = tag; x.ft = ft; x.gl = gl; x.gr = gr; x.ng = ng;
    x.li = li; x.ri = ri; x.clr = clr; x.srv = srv;
    x.ls = ls; x.rs = rs; x.dir = dir; x.win = win; x.st = st;
    vecs.push_back(x);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_act();
    return {17'd0, sif.left_inc, sif.right_inc, sif.score_clr, sif.serve,
            sif.left_score, sif.right_score, sif.serve_dir, sif.winner};
  endfunction

  task automatic cycle_in(logic ft, logic gl, logic gr, logic ng);
    @(negedge clk);
    sif.frame_tick = ft;
    sif.goal_left  = gl;
    sif.goal_right = gr;
    sif.new_game   = ng;
    #2;
    if (sif.left_inc)  li_cnt++;
    if (sif.right_inc) ri_cnt++;
    if (sif.serve)     srv_cnt++;
  endtask

  // Each frame is one tick cycle followed by one quiet cycle.
  task automatic run_frames(int n);
    srv_at = 0;
    for (int i = 1; i <= n; i++) begin
      cycle_in(1'b1, 1'b0, 1'b0, 1'b0);
      if (sif.serve) srv_at = i;
      cycle_in(1'b0, 1'b0, 1'b0, 1'b0);
      if (sif.serve) srv_at = -1;
    end
  endtask

  task automatic pulse_goal(bit left);
    cycle_in(1'b0, left, !left, 1'b0);
    cycle_in(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_tag(string tag);
    foreach (vecs[i]) begin
      if (vecs[i].tag == tag) begin
        cycle_in(vecs[i].ft, vecs[i].gl, vecs[i].gr, vecs[i].ng);
        check($sformatf("vec_%s%0d", tag, i), pack_act(),
              {17'd0, vecs[i].li, vecs[i].ri, vecs[i].clr, vecs[i].srv,
               vecs[i].ls, vecs[i].rs, vecs[i].dir, vecs[i].win});
        check($sformatf("vec_%s%0d_state", tag, i), 32'(dut.state), 32'(vecs[i].st));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //   tag ft gl gr ng  li ri clr srv  ls rs dir win state
    add("A", 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, IDLE);
    add("A", 1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, IDLE);
    add("A", 0, 1, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, IDLE);
    add("A", 0, 1, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, IDLE);
    add("A", 0, 0, 0, 1,  0, 0, 1, 0,   0, 0, 0, WIN_NONE, IDLE);
    add("A", 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, SERVE_WAIT);
    add("B", 0, 1, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, PLAY);
    add("B", 0, 1, 0, 0,  1, 0, 0, 0,   1, 0, 1, WIN_NONE, SCORED);
    for (int i = 0; i < 8; i++)
      add("B", 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, WIN_NONE, SCORED);
    add("B", 0, 0, 0, 0,  0, 0, 0, 0,   1, 0, 1, WIN_NONE, SCORED);
    add("C", 0, 1, 1, 0,  0, 0, 0, 0,   1, 0, 1, WIN_NONE, PLAY);
    add("C", 0, 0, 0, 0,  1, 0, 0, 0,   2, 0, 1, WIN_NONE, SCORED);
    add("C", 0, 0, 0, 0,  0, 0, 0, 0,   2, 0, 1, WIN_NONE, SCORED);
    add("D", 0, 0, 0, 1,  0, 0, 1, 0,   2, 9, 0, WIN_RIGHT, GAME_OVER);
    add("D", 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, SERVE_WAIT);
    add("E", 0, 0, 1, 1,  0, 0, 1, 0,   3, 2, 1, WIN_NONE, SCORED);
    add("E", 0, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, SERVE_WAIT);
    add("E", 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, WIN_NONE, SERVE_WAIT);

    sif.frame_tick = 1'b0;
    sif.goal_left  = 1'b0;
    sif.goal_right = 1'b0;
    sif.new_game   = 1'b0;
    li_cnt = 0; ri_cnt = 0; srv_cnt = 0; srv_at = 0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", pack_act(), 32'd0);
    check("reset_blink", 32'(sif.blink), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;

    apply_tag("A");
    check("idle_no_inc", 32'(li_cnt + ri_cnt), 32'd0);

    // First serve.
    srv_cnt = 0;
    run_frames(60);
    check("serve_pulses", 32'(srv_cnt), 32'd1);
    check("serve_at_tick", 32'(srv_at), 32'd60);
    check("play_after_serve", 32'(dut.state), 32'(PLAY));

    // Goal held for 10 cycles: exactly one increment.
    li_cnt = 0;
    apply_tag("B");
    check("held_goal_one_inc", 32'(li_cnt), 32'd1);
    run_frames(29);
    check("scored_29_ticks", 32'(dut.state), 32'(SCORED));
    run_frames(1);
    check("scored_30_ticks", 32'(dut.state), 32'(SERVE_WAIT));
    run_frames(60);
    check("serve2_at_tick", 32'(srv_at), 32'd60);

    // Simultaneous goals: left wins.
    ri_cnt = 0;
    apply_tag("C");
    check("simul_no_right_inc", 32'(ri_cnt), 32'd0);
    run_frames(30);
    run_frames(60);

    // Right player runs to 9.
    li_cnt = 0; ri_cnt = 0; srv_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      pulse_goal(1'b0);
      run_frames(30);
      check($sformatf("after_right_goal_%0d", i), 32'(dut.state),
            32'(i < 9 ? SERVE_WAIT : GAME_OVER));
      if (i < 9) run_frames(60);
    end
    check("right_inc_count", 32'(ri_cnt), 32'd9);
    check("left_inc_count", 32'(li_cnt), 32'd0);
    check("serves_during_run", 32'(srv_cnt), 32'd8);
    check("game_over_outputs", pack_act(), {17'd0, 4'b0000, 4'd2, 4'd9, DIR_LEFT, WIN_RIGHT});
    check("blink_on_entry", 32'(sif.blink), 32'(BLINK_ON));

    li_cnt = 0; ri_cnt = 0;
    pulse_goal(1'b1);
    pulse_goal(1'b0);
    check("game_over_ignores_goals", 32'(li_cnt + ri_cnt), 32'd0);
    check("game_over_scores_held", {24'd0, sif.left_score, sif.right_score}, {24'd0, 4'd2, 4'd9});
    run_frames(7);
    check("blink_before_8th", 32'(sif.blink), 32'(BLINK_ON));
    run_frames(1);
    check("blink_after_8th", 32'(sif.blink), 32'd0);
    run_frames(8);
    check("blink_after_16th", 32'(sif.blink), 32'(BLINK_ON));
    check("game_over_held", {30'd0, sif.winner}, {30'd0, WIN_RIGHT});

    // Restart from GAME_OVER.
    apply_tag("D");
    check("blink_cleared", 32'(sif.blink), 32'd0);
    run_frames(60);

    // Build 3/2 and restart in the middle of SCORED.
    pulse_goal(1'b1); run_frames(30); run_frames(60);
    pulse_goal(1'b1); run_frames(30); run_frames(60);
    pulse_goal(1'b0); run_frames(30); run_frames(60);
    pulse_goal(1'b0); run_frames(30); run_frames(60);
    pulse_goal(1'b1);
    run_frames(10);
    check("mid_scored_state", 32'(dut.state), 32'(SCORED));
    li_cnt = 0; ri_cnt = 0;
    apply_tag("E");
    check("restart_no_inc", 32'(li_cnt + ri_cnt), 32'd0);
    run_frames(60);
    check("restart_serve_at_tick", 32'(srv_at), 32'd60);
    check("restart_play", 32'(dut.state), 32'(PLAY));

    // Reset while an increment is pending.
    cycle_in(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_suppresses_inc", 32'(sif.left_inc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sif.goal_left = 1'b0;
    #2;
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_outputs", pack_act(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Game-flow controller for the pong score display.
- Turns raw goal events from ball logic into per-player score counts and one-cycle increment pulses that step the score digits.
- Times the post-goal pause and serve delay in video frames, issues the serve strobe, and detects the winner.
- Sits between ball/collision logic and the two score-digit instances.

Parameters:
- WIN_SCORE, 9, score that ends the game; legal range 1..9.
- SCORED_FRAMES, 30, frame ticks held in SCORED before moving on; legal range 1..255.
- SERVE_FRAMES, 60, frame ticks waited in SERVE_WAIT before the serve strobe; legal range 1..255.
- BLINK_FRAMES, 8, frame ticks per blink half-period (optional feature only); legal range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame (vsync start).
- goal_left  in  1  level from ball logic, high while ball is in the right goal (left player scores).
- goal_right  in  1  level, high while ball is in the left goal (right player scores).
- new_game  in  1  start/restart request, already debounced.
- left_inc  out  1  one-cycle increment pulse to the left score digit.
- right_inc  out  1  one-cycle increment pulse to the right score digit.
- score_clr  out  1  one-cycle clear pulse to both digits.
- left_score  out  4  left score count, 0..WIN_SCORE.
- right_score  out  4  right score count, 0..WIN_SCORE.
- serve  out  1  one-cycle ball-release strobe.
- serve_dir  out  1  serve direction: 0 = toward left, 1 = toward right.
- winner  out  2  00 = none, 01 = left, 10 = right.
- blink  out  1  winner-digit blink enable.

Behaviour:
- Reset values: state IDLE; all counts, pulses, serve_dir, winner and blink are 0; edge-detect registers 0; frame counter 0.
- Goal detection: rising edge of each goal input via a one-register delay (goal & ~goal_d). Edges are acted on only in PLAY; in all other states they are discarded.
- States:
  - IDLE: outputs static. new_game → SERVE_WAIT.
  - SERVE_WAIT: count frame_tick. On the SERVE_FRAMES-th tick, serve = 1 for that one cycle, then → PLAY.
  - PLAY: on a left edge, the next cycle has left_inc = 1, left_score+1, serve_dir = 1, then → SCORED. A right edge is symmetric: right_inc, right_score+1, serve_dir = 0.
  - SCORED: count SCORED_FRAMES ticks, then → GAME_OVER if either score equals WIN_SCORE, else → SERVE_WAIT.
  - GAME_OVER: winner set on entry and held. Only new_game leaves this state.
- Frame counter: cleared on every state entry. A frame_tick in the same cycle as state entry is not counted.
- Simultaneous left and right edges in PLAY: left has priority; the right edge is dropped.
- Scores never exceed WIN_SCORE: increments occur only in PLAY, and scoring at WIN_SCORE always leads to GAME_OVER. No wrap.
- new_game in any state except IDLE (including mid-SCORED and mid-SERVE_WAIT):
  - In the same cycle: score_clr = 1 for one cycle, both scores, winner and serve_dir cleared to 0, and the frame counter reset.
  - Next state is SERVE_WAIT.
  - new_game outranks a goal edge in the same cycle.
- new_game in IDLE behaves the same (score_clr pulses too).
- rst mid-operation: the synchronous reset returns everything to reset values at the next edge. Any pending inc or serve pulse is suppressed.
- left_inc and right_inc are never high in the same cycle. Neither is high in the same cycle as score_clr.

Optional Feature:
- SCORE_BLINK_EN defined: in GAME_OVER, blink toggles every BLINK_FRAMES frame ticks, starting at 1 on entry. It reads 0 in all other states and is cleared by new_game or rst.
- SCORE_BLINK_EN undefined: blink is tied to 0 and no blink counter is synthesized.

Decomposition:
- Package pong_pkg holds:
  - the state enum {IDLE, SERVE_WAIT, PLAY, SCORED, GAME_OVER};
  - winner codes WIN_NONE = 2'b00, WIN_LEFT = 2'b01, WIN_RIGHT = 2'b10;
  - direction constants DIR_LEFT = 0, DIR_RIGHT = 1.
- Sub-module frame_timer: 8-bit counter of frame_tick with a clear input and a terminal-count input; outputs a one-cycle done pulse. It is reused for the SCORED and SERVE_WAIT waits and for blink.

Test Plan:
1. rst high for 2 cycles → all outputs 0, state IDLE. A frame_tick then goal_left in IDLE → no left_inc, no serve.
2. new_game in IDLE, 60 frame_ticks → score_clr pulses once. serve is high for exactly one cycle, aligned with the 60th tick. State = PLAY.
3. In PLAY, goal_left held high for 10 cycles → exactly one left_inc one cycle after the rising edge, left_score = 1, serve_dir = 1. After 30 ticks → SERVE_WAIT.
4. goal_left and goal_right rise in the same cycle → left_inc only, right_score unchanged at 0.
5. Right player scores 9 times with WIN_SCORE = 9 → right_score = 9. After SCORED → winner = 2'b10, state GAME_OVER. Further goal edges are ignored. With SCORE_BLINK_EN, blink toggles every 8 ticks.
6. new_game during SCORED with scores 3/2 → score_clr pulse, scores 0/0, winner 0, next state SERVE_WAIT. A goal edge in the same cycle produces no inc pulse.
